// File: rtl/pulse_trigger_info_reader.sv
// Pulse trigger FIFO consumer.
// Pops 128-bit trigger-info words, checks trigger-number continuity and format,
// and emits each record as three 32-bit words on a valid/ready stream.
// It also keeps saturating per-type counters and sticky error flags.
module pulse_trigger_info_reader #(
    parameter int NUM_W = 24,
    parameter int TS_W  = 44,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             readout_done,
    input  logic             reset_trig_num,
    input  logic             fifo_valid,
    input  logic [127:0]     fifo_data,
    output logic             fifo_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             out_last,
    output logic             seq_error,
    output logic             fmt_error,
    output logic [7:0]       seq_err_cnt,
    output logic [CNT_W-1:0] laser_cnt,
    output logic [CNT_W-1:0] am_cnt,
    output logic [CNT_W-1:0] both_cnt,
    output logic [3:0]       state
);

    localparam logic [3:0] ST_IDLE  = 4'b0001;
    localparam logic [3:0] ST_WORD0 = 4'b0010;
    localparam logic [3:0] ST_WORD1 = 4'b0100;
    localparam logic [3:0] ST_WORD2 = 4'b1000;

    localparam int LEN_LSB = TS_W + NUM_W;

    // Fields of the incoming FIFO word
    logic [TS_W-1:0]  in_ts_s;
    logic [NUM_W-1:0] in_num_s;
    logic [1:0]       in_len_s;
    logic             in_pad_nz_s;

    assign in_ts_s     = fifo_data[TS_W-1:0];
    assign in_num_s    = fifo_data[LEN_LSB-1:TS_W];
    assign in_len_s    = fifo_data[LEN_LSB+1:LEN_LSB];
    assign in_pad_nz_s = |fifo_data[127:LEN_LSB+2];

    logic [3:0]       state_q, state_d;
    logic             fifo_ready_q, fifo_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             out_last_q, out_last_d;
    logic [1:0]       hold_len_q;
    logic [NUM_W-1:0] hold_num_q;
    logic [TS_W-1:0]  hold_ts_q;
    logic [NUM_W-1:0] exp_num_q;
    logic             seq_error_q, fmt_error_q;
    logic [7:0]       seq_err_cnt_q;
    logic [CNT_W-1:0] laser_cnt_q, am_cnt_q, both_cnt_q;
    logic             pop_s;
    logic             hs_s;

    assign pop_s = state_q[0] & fifo_valid & fifo_ready_q;
    assign hs_s  = out_valid_q & out_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one step per pop or per accepted output word
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (pop_s) state_d = ST_WORD0; else state_d = ST_IDLE;
            ST_WORD0: if (hs_s)  state_d = ST_WORD1; else state_d = ST_WORD0;
            ST_WORD1: if (hs_s)  state_d = ST_WORD2; else state_d = ST_WORD1;
            ST_WORD2: if (hs_s)  state_d = ST_IDLE;  else state_d = ST_WORD2;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output next-values: the stream registers only change on pop or handshake,
    // so data and last stay stable while the consumer stalls
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    out_valid_d = 1'b1;
                    out_data_d  = {4'hA, 2'b00, in_len_s, in_num_s};
                    out_last_d  = 1'b0;
                end else begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                end
            end
            ST_WORD0: begin
                if (hs_s) begin
                    out_data_d = {4'hB, 16'h0000, hold_ts_q[43:32]};
                    out_last_d = 1'b0;
                end else begin
                    out_data_d = out_data_q;
                end
            end
            ST_WORD1: begin
                if (hs_s) begin
                    out_data_d = hold_ts_q[31:0];
                    out_last_d = 1'b1;
                end else begin
                    out_data_d = out_data_q;
                end
            end
            ST_WORD2: begin
                if (hs_s) begin
                    out_valid_d = 1'b0;
                    out_data_d  = 32'h0000_0000;
                    out_last_d  = 1'b0;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                out_data_d  = 32'h0000_0000;
                out_last_d  = 1'b0;
            end
        endcase
        // Pop strobe is registered and only offered while the FSM sits in IDLE
        fifo_ready_d = enable & (state_d == ST_IDLE);
    end

    // Output and pop-strobe registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fifo_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= 32'h0000_0000;
            out_last_q   <= 1'b0;
        end else begin
            fifo_ready_q <= fifo_ready_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
        end
    end

    // Record holding register, loaded on every pop
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_len_q <= 2'b00;
            hold_num_q <= '0;
            hold_ts_q  <= '0;
        end else if (pop_s) begin
            hold_len_q <= in_len_s;
            hold_num_q <= in_num_s;
            hold_ts_q  <= in_ts_s;
        end
    end

    // Continuity tracking: compare with pre-update expectation, resync to the
    // received number, and let a readout/TTC reset override the next value
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_num_q     <= {{(NUM_W-1){1'b0}}, 1'b1};
            seq_error_q   <= 1'b0;
            seq_err_cnt_q <= 8'd0;
        end else begin
            if (pop_s && (in_num_s != exp_num_q)) begin
                seq_error_q <= 1'b1;
                if (seq_err_cnt_q != 8'hFF) begin
                    seq_err_cnt_q <= seq_err_cnt_q + 8'd1;
                end
            end
            if (readout_done || reset_trig_num) begin
                exp_num_q <= {{(NUM_W-1){1'b0}}, 1'b1};
            end else if (pop_s) begin
                exp_num_q <= in_num_s + {{(NUM_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Format flag and per-type saturating counters, updated in the pop cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fmt_error_q <= 1'b0;
            laser_cnt_q <= '0;
            am_cnt_q    <= '0;
            both_cnt_q  <= '0;
        end else if (pop_s) begin
            if (in_pad_nz_s || (in_len_s == 2'b00)) begin
                fmt_error_q <= 1'b1;
            end
            case (in_len_s)
                2'b10:   if (laser_cnt_q != {CNT_W{1'b1}}) laser_cnt_q <= laser_cnt_q + 1'b1;
                2'b01:   if (am_cnt_q != {CNT_W{1'b1}})    am_cnt_q    <= am_cnt_q + 1'b1;
                2'b11:   if (both_cnt_q != {CNT_W{1'b1}})  both_cnt_q  <= both_cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    assign state       = state_q;
    assign fifo_ready  = fifo_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_last    = out_last_q;
    assign seq_error   = seq_error_q;
    assign fmt_error   = fmt_error_q;
    assign seq_err_cnt = seq_err_cnt_q;
    assign laser_cnt   = laser_cnt_q;
    assign am_cnt      = am_cnt_q;
    assign both_cnt    = both_cnt_q;

endmodule

// File: tb/tb_pulse_trigger_info_reader.sv
// Directed self-checking bench for pulse_trigger_info_reader.
// Counters are built 4 bits wide so saturation is reachable in a short run.
module tb_pulse_trigger_info_reader;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          enable;
    logic          readout_done;
    logic          reset_trig_num;
    logic          fifo_valid;
    logic [127:0]  fifo_data;
    logic          fifo_ready;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_last;
    logic          seq_error;
    logic          fmt_error;
    logic [7:0]    seq_err_cnt;
    logic [CW-1:0] laser_cnt;
    logic [CW-1:0] am_cnt;
    logic [CW-1:0] both_cnt;
    logic [3:0]    state;

    int tests  = 0;
    int errors = 0;

    logic [31:0] cap_data [3];
    logic        cap_last [3];
    int          ncap;

    pulse_trigger_info_reader #(.NUM_W(24), .TS_W(44), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .readout_done(readout_done), .reset_trig_num(reset_trig_num),
        .fifo_valid(fifo_valid), .fifo_data(fifo_data), .fifo_ready(fifo_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .seq_error(seq_error), .fmt_error(fmt_error),
        .seq_err_cnt(seq_err_cnt), .laser_cnt(laser_cnt), .am_cnt(am_cnt),
        .both_cnt(both_cnt), .state(state)
    );

    always #12.5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_readout();
        readout_done = 1'b1;
        tick();
        readout_done = 1'b0;
    endtask

    // Offer one FIFO word, then drain the record with out_ready held high,
    // capturing each output word
    task automatic pop_record(input logic [1:0] len, input logic [23:0] num,
                              input logic [43:0] ts, input logic [57:0] pad,
                              input logic rd);
        int n;
        n = 0;
        enable = 1'b1;
        while (!fifo_ready && n < 20) begin tick(); n++; end
        tests++;
        if (fifo_ready !== 1'b1) begin
            errors++;
            $display("FAIL pop_wait: fifo_ready=%b required 1", fifo_ready);
        end
        fifo_data    = {pad, len, num, ts};
        fifo_valid   = 1'b1;
        readout_done = rd;
        tick();
        fifo_valid   = 1'b0;
        readout_done = 1'b0;
        out_ready    = 1'b1;
        ncap = 0;
        n = 0;
        while (out_valid && n < 10) begin
            if (ncap < 3) begin
                cap_data[ncap] = out_data;
                cap_last[ncap] = out_last;
            end
            ncap++;
            tick();
            n++;
        end
        tests++;
        if (out_valid !== 1'b0 || ncap != 3) begin
            errors++;
            $display("FAIL drain: words=%0d required 3, out_valid=%b", ncap, out_valid);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; readout_done = 1'b0; reset_trig_num = 1'b0;
        fifo_valid = 1'b0; fifo_data = 128'd0; out_ready = 1'b0;
        #30;
        tests++;
        if (state !== 4'b0001 || out_valid !== 1'b0 || fifo_ready !== 1'b0 ||
            seq_error !== 1'b0 || fmt_error !== 1'b0 || seq_err_cnt !== 8'd0 ||
            laser_cnt !== 4'd0 || am_cnt !== 4'd0 || both_cnt !== 4'd0) begin
            errors++;
            $display("FAIL reset: state=%b ov=%b fr=%b se=%b fe=%b sc=%0d l=%0d a=%0d b=%0d required idle/zero",
                     state, out_valid, fifo_ready, seq_error, fmt_error, seq_err_cnt, laser_cnt, am_cnt, both_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_pop_timing();
        enable = 1'b1; out_ready = 1'b1;
        tick();
        tests++;
        if (fifo_ready !== 1'b1) begin errors++; $display("FAIL ready_idle: got %b required 1", fifo_ready); end
        fifo_data  = {58'd0, 2'b10, 24'd1, 44'h123_4567_89AB};
        fifo_valid = 1'b1;
        tick();
        fifo_valid = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hA200_0001 || out_last !== 1'b0 || fifo_ready !== 1'b0) begin
            errors++;
            $display("FAIL word0: v=%b d=%h l=%b fr=%b required 1 A2000001 0 0", out_valid, out_data, out_last, fifo_ready);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hB000_0123 || out_last !== 1'b0 || fifo_ready !== 1'b0) begin
            errors++;
            $display("FAIL word1: v=%b d=%h l=%b fr=%b required 1 B0000123 0 0", out_valid, out_data, out_last, fifo_ready);
        end
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h4567_89AB || out_last !== 1'b1 || fifo_ready !== 1'b0) begin
            errors++;
            $display("FAIL word2: v=%b d=%h l=%b fr=%b required 1 456789AB 1 0", out_valid, out_data, out_last, fifo_ready);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || fifo_ready !== 1'b1 || state !== 4'b0001) begin
            errors++;
            $display("FAIL record_end: v=%b fr=%b st=%b required 0 1 0001", out_valid, fifo_ready, state);
        end
        tests++;
        if (laser_cnt !== 4'd1 || seq_error !== 1'b0 || fmt_error !== 1'b0) begin
            errors++;
            $display("FAIL pop_status: laser=%0d se=%b fe=%b required 1 0 0", laser_cnt, seq_error, fmt_error);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        fifo_data  = {58'd0, 2'b01, 24'd2, 44'h123_4567_89AB};
        fifo_valid = 1'b1;
        tick();
        fifo_valid = 1'b0;
        tick();
        tests++;
        if (out_valid !== 1'b1 || out_data !== 32'hA100_0002) begin
            errors++;
            $display("FAIL bp_word0: v=%b d=%h required 1 A1000002", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_data !== 32'hB000_0123 || out_last !== 1'b0 || fifo_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: v=%b d=%h l=%b fr=%b required 1 B0000123 0 0",
                         i, out_valid, out_data, out_last, fifo_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        tests++;
        if (out_data !== 32'h4567_89AB || out_last !== 1'b1) begin
            errors++;
            $display("FAIL bp_word2: d=%h l=%b required 456789AB 1", out_data, out_last);
        end
        tick();
        tests++;
        if (out_valid !== 1'b0 || am_cnt !== 4'd1 || seq_error !== 1'b0) begin
            errors++;
            $display("FAIL bp_end: v=%b am=%0d se=%b required 0 1 0", out_valid, am_cnt, seq_error);
        end
    endtask

    task automatic test_continuity();
        pulse_readout();
        pop_record(2'b10, 24'd1, 44'd10, 58'd0, 1'b0);
        pop_record(2'b10, 24'd2, 44'd11, 58'd0, 1'b0);
        tests++;
        if (seq_error !== 1'b0) begin errors++; $display("FAIL seq_in_order: se=%b required 0", seq_error); end
        pop_record(2'b10, 24'd4, 44'd12, 58'd0, 1'b0);
        tests++;
        if (seq_error !== 1'b1 || seq_err_cnt !== 8'd1) begin
            errors++;
            $display("FAIL seq_gap: se=%b cnt=%0d required 1 1", seq_error, seq_err_cnt);
        end
        pop_record(2'b10, 24'd5, 44'd13, 58'd0, 1'b0);
        tests++;
        if (seq_err_cnt !== 8'd1) begin errors++; $display("FAIL seq_resync: cnt=%0d required 1", seq_err_cnt); end
        pulse_readout();
        for (int k = 1; k <= 5; k++) pop_record(2'b10, k[23:0], 44'd20, 58'd0, 1'b0);
        tests++;
        if (seq_err_cnt !== 8'd1) begin errors++; $display("FAIL seq_after_readout: cnt=%0d required 1", seq_err_cnt); end
        pop_record(2'b10, 24'd6, 44'd21, 58'd0, 1'b1);
        tests++;
        if (seq_err_cnt !== 8'd1) begin errors++; $display("FAIL seq_coincident: cnt=%0d required 1", seq_err_cnt); end
        pop_record(2'b10, 24'd1, 44'd22, 58'd0, 1'b0);
        tests++;
        if (seq_err_cnt !== 8'd1 || laser_cnt !== 4'd12) begin
            errors++;
            $display("FAIL seq_restart: cnt=%0d laser=%0d required 1 12", seq_err_cnt, laser_cnt);
        end
    endtask

    task automatic test_wrap();
        pop_record(2'b11, 24'hFF_FFFF, 44'd30, 58'd0, 1'b0);
        tests++;
        if (seq_err_cnt !== 8'd2) begin errors++; $display("FAIL wrap_jump: cnt=%0d required 2", seq_err_cnt); end
        pop_record(2'b11, 24'h00_0000, 44'd31, 58'd0, 1'b0);
        tests++;
        if (seq_err_cnt !== 8'd2 || both_cnt !== 4'd2) begin
            errors++;
            $display("FAIL wrap_zero: cnt=%0d both=%0d required 2 2", seq_err_cnt, both_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int k = 1; k <= 16; k++) pop_record(2'b01, k[23:0], 44'd40, 58'd0, 1'b0);
        tests++;
        if (am_cnt !== 4'hF || seq_err_cnt !== 8'd2 || laser_cnt !== 4'd12 || both_cnt !== 4'd2) begin
            errors++;
            $display("FAIL am_saturate: am=%h cnt=%0d laser=%0d both=%0d required F 2 12 2",
                     am_cnt, seq_err_cnt, laser_cnt, both_cnt);
        end
    endtask

    task automatic test_format();
        logic [57:0] pad;
        pad = 58'd0;
        pad[30] = 1'b1;
        tests++;
        if (fmt_error !== 1'b0) begin errors++; $display("FAIL fmt_before: fe=%b required 0", fmt_error); end
        pop_record(2'b10, 24'd17, 44'hABC_DEAD_BEEF, pad, 1'b0);
        tests++;
        if (fmt_error !== 1'b1 || laser_cnt !== 4'd13) begin
            errors++;
            $display("FAIL fmt_pad: fe=%b laser=%0d required 1 13", fmt_error, laser_cnt);
        end
        tests++;
        if (cap_data[0] !== 32'hA200_0011 || cap_data[1] !== 32'hB000_0ABC ||
            cap_data[2] !== 32'hDEAD_BEEF || cap_last[2] !== 1'b1 || cap_last[1] !== 1'b0) begin
            errors++;
            $display("FAIL fmt_forward: %h %h %h last=%b required A2000011 B0000ABC DEADBEEF 1",
                     cap_data[0], cap_data[1], cap_data[2], cap_last[2]);
        end
        pop_record(2'b00, 24'd18, 44'd50, 58'd0, 1'b0);
        tests++;
        if (fmt_error !== 1'b1 || laser_cnt !== 4'd13 || am_cnt !== 4'hF || both_cnt !== 4'd2 ||
            cap_data[0] !== 32'hA000_0012 || seq_err_cnt !== 8'd2) begin
            errors++;
            $display("FAIL fmt_len0: fe=%b l=%0d a=%h b=%0d w0=%h sc=%0d required 1 13 F 2 A0000012 2",
                     fmt_error, laser_cnt, am_cnt, both_cnt, cap_data[0], seq_err_cnt);
        end
    endtask

    task automatic test_reset_mid();
        out_ready  = 1'b0;
        fifo_data  = {58'd0, 2'b10, 24'd19, 44'd60};
        fifo_valid = 1'b1;
        tick();
        fifo_valid = 1'b0;
        out_ready  = 1'b1;
        tick();
        out_ready  = 1'b0;
        tests++;
        if (state !== 4'b0100 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_setup: st=%b v=%b required 0100 1", state, out_valid);
        end
        #3;
        reset_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || state !== 4'b0001) begin
            errors++;
            $display("FAIL mid_async: v=%b st=%b required 0 0001", out_valid, state);
        end
        tick();
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        tests++;
        if (state !== 4'b0001 || seq_error !== 1'b0 || fmt_error !== 1'b0 || seq_err_cnt !== 8'd0 ||
            laser_cnt !== 4'd0 || am_cnt !== 4'd0 || both_cnt !== 4'd0) begin
            errors++;
            $display("FAIL mid_cleared: st=%b se=%b fe=%b sc=%0d l=%0d a=%0d b=%0d required 0001 and zeros",
                     state, seq_error, fmt_error, seq_err_cnt, laser_cnt, am_cnt, both_cnt);
        end
        pop_record(2'b10, 24'd1, 44'd70, 58'd0, 1'b0);
        tests++;
        if (seq_error !== 1'b0 || seq_err_cnt !== 8'd0 || laser_cnt !== 4'd1) begin
            errors++;
            $display("FAIL mid_restart: se=%b sc=%0d l=%0d required 0 0 1", seq_error, seq_err_cnt, laser_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_pop_timing();
        test_backpressure();
        test_continuity();
        test_wrap();
        test_saturation();
        test_format();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/pulse_trigger_info_reader.md
Name: pulse_trigger_info_reader

Overview:
- Consumer end of the Pulse Trigger FIFO. Pops each 128-bit trigger-info word written by the front-panel trigger receiver.
- Unpacks each word and checks trigger-number continuity and format.
- Serializes each trigger record as three 32-bit words on a valid/ready stream to the trigger processor / readout path.
- Keeps per-type trigger counters and sticky error status for the status registers.

Parameters:
- NUM_W, 24, trigger number width
- TS_W, 44, trigger timestamp width
- CNT_W, 16, width of each per-type saturating counter

Ports:
- clk  in  1  40 MHz TTC clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  permits popping the FIFO
- readout_done  in  1  readout complete; expected trigger number returns to 1
- reset_trig_num  in  1  TTC Channel B reset; same effect as readout_done
- fifo_valid  in  1  FIFO word available
- fifo_data  in  128  {58'd0, length[1:0], num[23:0], timestamp[43:0]}
- fifo_ready  out  1  pop strobe (FWFT FIFO, word consumed when valid&ready)
- out_valid  out  1  output word valid
- out_ready  in  1  downstream accepts
- out_data  out  32  output word
- out_last  out  1  marks word 2 of the record
- seq_error  out  1  sticky trigger-number mismatch
- fmt_error  out  1  sticky format error
- seq_err_cnt  out  8  saturating mismatch count
- laser_cnt  out  CNT_W  length==2'b10 records, saturating
- am_cnt  out  CNT_W  length==2'b01 records, saturating
- both_cnt  out  CNT_W  length==2'b11 records, saturating
- state  out  4  one-hot FSM state

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE (4'b0001).
  - All outputs and counters 0.
  - Internal expected number = 1; holding register = 0.
  - Reset mid-record drops the record; out_valid falls immediately with reset.
- States (one-hot): IDLE, WORD0, WORD1, WORD2.
- IDLE:
  - fifo_ready = enable (registered; asserted only in IDLE).
  - On fifo_valid&fifo_ready in cycle N: latch fifo_data, update status, next state WORD0.
  - out_valid=1 with word0 in cycle N+1.
  - fifo_ready=0 from N+1 until the return to IDLE.
- WORD0: out_data = {4'hA, 2'b00, length[1:0], num[23:0]}; advance to WORD1 on out_ready.
- WORD1: out_data = {4'hB, 16'd0, ts[43:32]}; advance to WORD2 on out_ready.
- WORD2: out_data = ts[31:0], out_last=1; on out_ready go to IDLE.
  - Minimum record period is 4 cycles (the IDLE pop cycle plus 3 words).
- Output stall rules:
  - While out_valid=1 and out_ready=0, out_data/out_last hold stable.
  - out_valid never drops without a handshake, except on reset.
- Continuity check (evaluated in the pop cycle):
  - If num != expected: seq_error<=1, seq_err_cnt+1 (saturate at 255).
  - Expected <= num+1 (wraps 2^24-1 -> 0), i.e. resync to the received number.
- readout_done or reset_trig_num:
  - Expected <= 1.
  - If coincident with a pop, the comparison uses the pre-update expected, and the reset wins for the next value.
- Format check in the pop cycle: fifo_data[127:70]!=0 or length==2'b00 -> fmt_error<=1.
  - The record is still forwarded unchanged.
  - length==00 increments no type counter.
- Per-type counters increment in the pop cycle and saturate at all-ones.
- Sticky errors clear only on reset.
- enable:
  - Low blocks new pops only; an in-flight record completes.
  - Deasserting enable in the same cycle as fifo_valid: no pop, because fifo_ready is registered from the previous cycle's enable.

Test Plan:
- Pop timing and packing: enable=1, out_ready=1, FIFO word num=1, len=2'b10, ts=44'h123_4567_89AB -> cycle N+1 A2000001, N+2 B0000123, N+3 456789AB with last=1; laser_cnt=1; no errors; fifo_ready high again at N+4.
- Output backpressure: hold out_ready=0 for 5 cycles on word1 -> out_data stays B0000123 and fifo_ready stays 0 throughout; record completes after release.
- Continuity:
  - nums 1,2,4 -> seq_error=1, seq_err_cnt=1; following num 5 accepted without new error.
  - readout_done, then num 1 -> no error.
  - readout_done coincident with pop of num 6 while expecting 6 -> no error; next expected 1.
- Wrap and saturation:
  - num 24'hFFFFFF then 0 -> no error.
  - Force am_cnt to 16'hFFFF and pop len=01 -> am_cnt stays FFFF.
- Format errors: bit 100 set -> fmt_error=1 and record forwarded; len=00 -> fmt_error, no type counter changes.
- Reset mid-record: assert reset_n=0 during WORD1 -> out_valid=0 without waiting for a clock edge; after release state=0001, counters 0, next num 1 gives no error.
